// File: rtl/addsub_digit_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB digit first,
// with a start/busy/done handshake and registered sum, carry-out and signed overflow.
module addsub_digit_serial #(
   parameter int WIDTH = 6,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sel,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int NUM_DIGITS = WIDTH / DIGIT;
   localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               r_state;
   state_t               w_nextState;

   logic [WIDTH-1:0]     r_x;
   logic [WIDTH-1:0]     r_y;
   logic [WIDTH-1:0]     r_shadow;
   logic                 r_sel;
   logic                 r_carry;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_sum;
   logic                 r_cOut;
   logic                 r_ovf;

   logic [DIGIT-1:0]     w_a;
   logic [DIGIT-1:0]     w_b;
   logic [DIGIT:0]       w_res;
   logic [DIGIT-1:0]     w_s;
   logic                 w_cNext;
   logic                 w_cMsb;
   logic                 w_lastDigit;
   logic [WIDTH+DIGIT-1:0] w_shadowCat;
   logic [WIDTH-1:0]     w_shadowNext;

   // Operands shift right each RUN cycle, so the active digit is always the low slice.
   assign w_a          = r_x[DIGIT-1:0];
   assign w_b          = r_y[DIGIT-1:0] ^ {DIGIT{r_sel}};
   assign w_res        = {1'b0, w_a} + {1'b0, w_b} + {{DIGIT{1'b0}}, r_carry};
   assign w_s          = w_res[DIGIT-1:0];
   assign w_cNext      = w_res[DIGIT];
   assign w_cMsb       = w_s[DIGIT-1] ^ w_a[DIGIT-1] ^ w_b[DIGIT-1];
   assign w_lastDigit  = (r_cnt == CW'(NUM_DIGITS - 1));
   assign w_shadowCat  = {w_s, r_shadow};
   assign w_shadowNext = w_shadowCat[WIDTH+DIGIT-1:DIGIT];

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = RUN;
         RUN:     if (w_lastDigit) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != IDLE);
      done = (r_state == DONE);
   end

   // Results are loaded only on the final digit, so they hold through the next operation's RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= '0;
         r_y      <= '0;
         r_shadow <= '0;
         r_sel    <= 1'b0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_cOut   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_x     <= x;
                  r_y     <= y;
                  r_sel   <= sel;
                  r_carry <= sel;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_x      <= r_x >> DIGIT;
               r_y      <= r_y >> DIGIT;
               r_shadow <= w_shadowNext;
               r_carry  <= w_cNext;
               r_cnt    <= r_cnt + 1'b1;
               if (w_lastDigit) begin
                  r_sum  <= w_shadowNext;
                  r_cOut <= w_cNext;
                  r_ovf  <= w_cMsb ^ w_cNext;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum      = r_sum;
   assign c_out    = r_cOut;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Bench for addsub_digit_serial: four instances (WIDTH=6, DIGIT=1,2,3,6) share stimulus
// and are each compared against an arithmetic reference model.
module tb_addsub_digit_serial;

   localparam int W  = 6;
   localparam int NI = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sel;
   logic [W-1:0] x;
   logic [W-1:0] y;

   logic         oBusy [NI];
   logic         oDone [NI];
   logic [W-1:0] oSum  [NI];
   logic         oCout [NI];
   logic         oOvf  [NI];

   int assertCount = 0;
   int failCount   = 0;

   generate
      for (genvar g = 0; g < NI; g++) begin : gDut
         addsub_digit_serial #(
            .WIDTH(W),
            .DIGIT((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6)
         ) uDut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .sel     (sel),
            .x       (x),
            .y       (y),
            .busy    (oBusy[g]),
            .done    (oDone[g]),
            .sum     (oSum[g]),
            .c_out   (oCout[g]),
            .overflow(oOvf[g])
         );
      end
   endgenerate

   always #5 clk = ~clk;

   function automatic int digitOf(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         2:       return 3;
         default: return 6;
      endcase
   endfunction

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic void model(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic as,
                                 output logic [W-1:0] r, output logic c, output logic v);
      int ux, uy, sx, sy, full, sres;
      ux = int'(ax);
      uy = int'(ay);
      sx = (ux >= 32) ? ux - 64 : ux;
      sy = (uy >= 32) ? uy - 64 : uy;
      if (as) begin
         full = ux - uy;
         c    = (ux >= uy);
         sres = sx - sy;
      end else begin
         full = ux + uy;
         c    = (full >= 64);
         sres = sx + sy;
      end
      r = full[W-1:0];
      v = (sres > 31) || (sres < -32);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         assertCount++;
         if ({oBusy[i], oDone[i], oSum[i], oCout[i], oOvf[i]} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset inst%0d: got busy=%b done=%b sum=%b c=%b v=%b, want all 0",
                     i, oBusy[i], oDone[i], oSum[i], oCout[i], oOvf[i]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One operation with start pulsed for a single edge; checks latency, single done, result.
   task automatic doOperation(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic as,
                              input string tag);
      int           cnt    [NI];
      int           cyc    [NI];
      logic [W-1:0] gotSum [NI];
      logic         gotC   [NI];
      logic         gotV   [NI];
      logic [W-1:0] eS;
      logic         eC, eV;
      model(ax, ay, as, eS, eC, eV);
      for (int i = 0; i < NI; i++) begin
         cnt[i] = 0; cyc[i] = -1; gotSum[i] = '0; gotC[i] = 1'b0; gotV[i] = 1'b0;
      end
      @(negedge clk);
      x = ax; y = ay; sel = as; start = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         assertCount++;
         if (oBusy[i] !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL %s busy inst%0d: got %b want 1", tag, i, oBusy[i]);
         end
      end
      @(negedge clk);
      start = 1'b0; x = W'($urandom); y = W'($urandom); sel = 1'($urandom);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            if (oDone[i] === 1'b1) begin
               cnt[i]++;
               if (cyc[i] < 0) begin
                  cyc[i] = c; gotSum[i] = oSum[i]; gotC[i] = oCout[i]; gotV[i] = oOvf[i];
               end
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         assertCount++;
         if (cnt[i] != 1 || cyc[i] != W / digitOf(i)) begin
            failCount++;
            $display("[TB] FAIL %s done inst%0d: got %0d pulses at cycle %0d, want 1 at cycle %0d",
                     tag, i, cnt[i], cyc[i], W / digitOf(i));
         end
         assertCount++;
         if (gotSum[i] !== eS || gotC[i] !== eC || gotV[i] !== eV) begin
            failCount++;
            $display("[TB] FAIL %s result inst%0d: got sum=%b c=%b v=%b want sum=%b c=%b v=%b",
                     tag, i, gotSum[i], gotC[i], gotV[i], eS, eC, eV);
         end
         assertCount++;
         if (oBusy[i] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s idle inst%0d: got busy=%b want 0", tag, i, oBusy[i]);
         end
      end
   endtask

   task automatic test_directed();
      doOperation(6'b000001, 6'b000100, 1'b0, "add_small");
      doOperation(6'b000000, 6'b111111, 1'b1, "sub_borrow");
      doOperation(6'b111111, 6'b000001, 1'b0, "add_wrap");
      doOperation(6'b011111, 6'b000001, 1'b0, "add_posovf");
      doOperation(6'b100000, 6'b100000, 1'b0, "add_negovf");
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++)
         doOperation(W'($urandom), W'($urandom), 1'($urandom), "random");
   endtask

   // start held high with operands changing every cycle: an instance accepts at edges
   // 0, N+2, 2(N+2), ... and pulses done N edges after each acceptance.
   task automatic test_back_to_back();
      localparam int NE = 40;
      logic [W-1:0] opX [NE];
      logic [W-1:0] opY [NE];
      logic         opS [NE];
      logic         held [NI];
      logic [W-1:0] hSum [NI];
      logic [W-1:0] eS;
      logic         eC, eV, expDone;
      int           nd, acc;
      for (int e = 0; e < NE; e++) begin
         opX[e] = W'($urandom); opY[e] = W'($urandom); opS[e] = 1'($urandom);
      end
      for (int i = 0; i < NI; i++) begin
         held[i] = 1'b0; hSum[i] = '0;
      end
      @(negedge clk);
      x = opX[0]; y = opY[0]; sel = opS[0]; start = 1'b1;
      for (int e = 0; e < NE; e++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            nd      = W / digitOf(i);
            expDone = (e >= nd) && (((e - nd) % (nd + 2)) == 0);
            assertCount++;
            if (oDone[i] !== expDone) begin
               failCount++;
               $display("[TB] FAIL b2b done inst%0d edge %0d: got %b want %b", i, e, oDone[i], expDone);
            end
            if (expDone) begin
               acc = e - nd;
               model(opX[acc], opY[acc], opS[acc], eS, eC, eV);
               assertCount++;
               if (oSum[i] !== eS || oCout[i] !== eC || oOvf[i] !== eV) begin
                  failCount++;
                  $display("[TB] FAIL b2b result inst%0d edge %0d: got sum=%b c=%b v=%b want sum=%b c=%b v=%b",
                           i, e, oSum[i], oCout[i], oOvf[i], eS, eC, eV);
               end
               held[i] = 1'b1;
               hSum[i] = eS;
            end else if (held[i]) begin
               assertCount++;
               if (oSum[i] !== hSum[i]) begin
                  failCount++;
                  $display("[TB] FAIL b2b hold inst%0d edge %0d: got sum=%b want %b", i, e, oSum[i], hSum[i]);
               end
            end
         end
         @(negedge clk);
         if (e + 1 < NE) begin
            x = opX[e+1]; y = opY[e+1]; sel = opS[e+1];
         end else begin
            start = 1'b0;
         end
      end
      repeat (10) @(posedge clk);
   endtask

   // Reset asserted at the third compute edge of the bit-serial instance.
   task automatic test_reset_mid_run();
      int cnt [NI];
      @(negedge clk);
      x = 6'b010101; y = 6'b001011; sel = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      assertCount++;
      if (oBusy[0] !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL midrst prebusy inst0: got %b want 1", oBusy[0]);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         assertCount++;
         if ({oBusy[i], oDone[i], oSum[i], oCout[i], oOvf[i]} !== '0) begin
            failCount++;
            $display("[TB] FAIL midrst clear inst%0d: got busy=%b done=%b sum=%b c=%b v=%b, want all 0",
                     i, oBusy[i], oDone[i], oSum[i], oCout[i], oOvf[i]);
         end
         cnt[i] = 0;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++)
            if (oDone[i] === 1'b1) cnt[i]++;
      end
      for (int i = 0; i < NI; i++) begin
         assertCount++;
         if (cnt[i] != 0) begin
            failCount++;
            $display("[TB] FAIL midrst nodone inst%0d: got %0d pulses want 0", i, cnt[i]);
         end
      end
      doOperation(6'b101101, 6'b010110, 1'b1, "after_reset");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sel = 1'b0; x = '0; y = '0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
